// File: rtl/commit_pkg.sv
// Shared types, defaults and helpers for the writeback commit arbiter.
package commit_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned RN_W_DEF   = 6;
    localparam int unsigned RN_NONE    = 0;

    // Round-robin pointer width: clog2 of the channel count, never below 1.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating priority pick: first requester at or after ptr, wrapping once around.
module rr_select
    import commit_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned pos;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!gnt_any && req[pos]) begin
                gnt_any     = 1'b1;
                gnt_oh[pos] = 1'b1;
                gnt_idx     = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// Writeback arbiter: round-robin retirement of execution results onto registered
// register-file write ports. Define COMMIT_BYPASS_EN to drive the fwd_* bypass.
module commit_arbiter
    import commit_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 5,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RN_W      = RN_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_result,
    input  logic [NUM_UNITS*RN_W-1:0]     unit_rn,
    output logic [NUM_UNITS-1:0]          unit_stall,
    input  logic                          hold,
    output logic [WB_PORTS-1:0]           wb_en,
    output logic [WB_PORTS*RN_W-1:0]      wb_rn,
    output logic [WB_PORTS*DATA_W-1:0]    wb_data,
    output logic [WB_PORTS-1:0]           fwd_valid,
    output logic [WB_PORTS*RN_W-1:0]      fwd_rn,
    output logic [WB_PORTS*DATA_W-1:0]    fwd_data
);

    localparam int unsigned PTR_W = ptr_w(NUM_UNITS);

    logic [RN_W-1:0]     ch_rn   [NUM_UNITS];
    logic [DATA_W-1:0]   ch_data [NUM_UNITS];
    logic [NUM_UNITS-1:0] cand_c;
    logic [NUM_UNITS-1:0] zero_rn_c;
    logic [NUM_UNITS-1:0] granted_c;

    logic [WB_PORTS-1:0]        port_any;
    logic [WB_PORTS*PTR_W-1:0]  port_idx;
    logic [WB_PORTS*RN_W-1:0]   port_rn;
    logic [WB_PORTS*DATA_W-1:0] port_data;

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [WB_PORTS-1:0]        wb_en_q, wb_en_d;
    logic [WB_PORTS*RN_W-1:0]   wb_rn_q, wb_rn_d;
    logic [WB_PORTS*DATA_W-1:0] wb_data_q, wb_data_d;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_ch
        assign ch_rn[i]   = unit_rn[i*RN_W +: RN_W];
        assign ch_data[i] = unit_result[i*DATA_W +: DATA_W];
    end

    // rn==0 results retire without a port; everything else competes for ports.
    always_comb begin
        cand_c    = '0;
        zero_rn_c = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            zero_rn_c[i] = unit_valid[i] & ~hold & (ch_rn[i] == RN_W'(RN_NONE));
            cand_c[i]    = unit_valid[i] & ~hold & (ch_rn[i] != RN_W'(RN_NONE));
        end
    end

    // One selector per port; each masks channels already granted and rns already written.
    for (genvar k = 0; k < WB_PORTS; k++) begin : g_port
        logic [NUM_UNITS-1:0] taken_in;
        logic [NUM_UNITS-1:0] blk_in;
        logic [NUM_UNITS-1:0] req;
        logic [NUM_UNITS-1:0] oh;
        logic [PTR_W-1:0]     idx;
        logic                 any;
        logic [RN_W-1:0]      rn_sel;
        logic [DATA_W-1:0]    data_sel;

        if (k == 0) begin : g_first
            assign taken_in = '0;
            assign blk_in   = '0;
        end else begin : g_next
            always_comb begin
                taken_in = g_port[k-1].taken_in | g_port[k-1].oh;
                blk_in   = g_port[k-1].blk_in;
                for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                    if (g_port[k-1].any && (ch_rn[i] == g_port[k-1].rn_sel)) blk_in[i] = 1'b1;
                end
            end
        end

        assign req = cand_c & ~taken_in & ~blk_in;

        rr_select #(
            .N  (NUM_UNITS),
            .PW (PTR_W)
        ) u_sel (
            .req     (req),
            .ptr     (rr_ptr_q),
            .gnt_oh  (oh),
            .gnt_idx (idx),
            .gnt_any (any)
        );

        always_comb begin
            rn_sel   = '0;
            data_sel = '0;
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                if (oh[i]) begin
                    rn_sel   = rn_sel | ch_rn[i];
                    data_sel = data_sel | ch_data[i];
                end
            end
        end

        assign port_any[k]                  = any;
        assign port_idx[k*PTR_W +: PTR_W]   = idx;
        assign port_rn[k*RN_W +: RN_W]      = rn_sel;
        assign port_data[k*DATA_W +: DATA_W] = data_sel;
    end

    assign granted_c  = g_port[WB_PORTS-1].taken_in | g_port[WB_PORTS-1].oh;
    assign unit_stall = unit_valid & ~(zero_rn_c | granted_c);

    // Pointer moves past the last channel granted a port; ports fill in scan order.
    int unsigned nxt;
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        nxt       = 0;
        wb_en_d   = port_any;
        wb_rn_d   = port_rn;
        wb_data_d = port_data;
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            if (port_any[k]) begin
                nxt = 32'(port_idx[k*PTR_W +: PTR_W]) + 1;
                if (nxt >= NUM_UNITS) nxt = 0;
                rr_ptr_d = PTR_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wb_en_q   <= '0;
            wb_rn_q   <= '0;
            wb_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_en_q   <= wb_en_d;
            wb_rn_q   <= wb_rn_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rn   = wb_rn_q;
    assign wb_data = wb_data_q;

`ifdef COMMIT_BYPASS_EN
    // Same-cycle view of the grant mux, forced quiet while in reset.
    assign fwd_valid = rst_n ? port_any  : '0;
    assign fwd_rn    = rst_n ? port_rn   : '0;
    assign fwd_data  = rst_n ? port_data : '0;
`else
    assign fwd_valid = '0;
    assign fwd_rn    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed self-checking bench for commit_arbiter (default 5 units, 2 ports).
module tb_commit_arbiter;

    logic         clk;
    logic         rst_n;
    logic [4:0]   unit_valid;
    logic [319:0] unit_result;
    logic [29:0]  unit_rn;
    logic [4:0]   unit_stall;
    logic         hold;
    logic [1:0]   wb_en;
    logic [11:0]  wb_rn;
    logic [127:0] wb_data;
    logic [1:0]   fwd_valid;
    logic [11:0]  fwd_rn;
    logic [127:0] fwd_data;

    int n_vec;
    int n_err;

    commit_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .unit_valid  (unit_valid),
        .unit_result (unit_result),
        .unit_rn     (unit_rn),
        .unit_stall  (unit_stall),
        .hold        (hold),
        .wb_en       (wb_en),
        .wb_rn       (wb_rn),
        .wb_data     (wb_data),
        .fwd_valid   (fwd_valid),
        .fwd_rn      (fwd_rn),
        .fwd_data    (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ch(input int i, input logic v, input logic [5:0] rn, input logic [63:0] d);
        unit_valid[i]          = v;
        unit_rn[i*6 +: 6]      = rn;
        unit_result[i*64 +: 64] = d;
    endtask

    task automatic clear_all();
        unit_valid  = '0;
        unit_rn     = '0;
        unit_result = '0;
        hold        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        clear_all();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_all();
        for (int i = 0; i < 5; i++) set_ch(i, 1'b1, 6'(i + 1), 64'(i));
        rst_n = 1'b0;
        step();
        step();
        n_vec++;
        if (wb_en !== 2'b00 || wb_rn !== 12'h0 || wb_data !== 128'h0) begin
            n_err++;
            $display("FAIL reset_wb got en=%b rn=%h data=%h want all 0", wb_en, wb_rn, wb_data);
        end
        n_vec++;
        if (fwd_valid !== 2'b00 || fwd_rn !== 12'h0) begin
            n_err++;
            $display("FAIL reset_fwd got valid=%b rn=%h want 0", fwd_valid, fwd_rn);
        end
        n_vec++;
        if (dut.rr_ptr_q !== 3'd0) begin
            n_err++;
            $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr_q);
        end
        clear_all();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_ports_default();
        set_ch(0, 1'b1, 6'd5, 64'hA);
        set_ch(1, 1'b1, 6'd6, 64'hB);
        set_ch(2, 1'b1, 6'd7, 64'hC);
        #1;
        n_vec++;
        if (unit_stall !== 5'b00100) begin
            n_err++;
            $display("FAIL dflt_stall got %b want 00100", unit_stall);
        end
        step();
        n_vec++;
        if (wb_en !== 2'b11 || wb_rn !== {6'd6, 6'd5} || wb_data !== {64'hB, 64'hA}) begin
            n_err++;
            $display("FAIL dflt_n1 got en=%b rn=%h data=%h want en=11 rn=185 data=B,A", wb_en, wb_rn, wb_data);
        end
        n_vec++;
        if (dut.rr_ptr_q !== 3'd2) begin
            n_err++;
            $display("FAIL dflt_ptr got %0d want 2", dut.rr_ptr_q);
        end
        set_ch(0, 1'b0, 6'd0, 64'h0);
        set_ch(1, 1'b0, 6'd0, 64'h0);
        #1;
        n_vec++;
        if (unit_stall !== 5'b00000) begin
            n_err++;
            $display("FAIL dflt_stall2 got %b want 00000", unit_stall);
        end
        step();
        n_vec++;
        if (wb_en !== 2'b01 || wb_rn[5:0] !== 6'd7 || wb_data[63:0] !== 64'hC) begin
            n_err++;
            $display("FAIL dflt_n2 got en=%b rn=%0d data=%h want en=01 rn=7 data=C", wb_en, wb_rn[5:0], wb_data[63:0]);
        end
        clear_all();
        step();
        n_vec++;
        if (wb_en !== 2'b00 || dut.rr_ptr_q !== 3'd3) begin
            n_err++;
            $display("FAIL dflt_idle got en=%b ptr=%0d want en=00 ptr=3", wb_en, dut.rr_ptr_q);
        end
    endtask

    task automatic test_fairness();
        int first_ch [5] = '{0, 2, 4, 1, 3};
        int second_ch[5] = '{1, 3, 0, 2, 4};
        int ptr_after[5] = '{2, 4, 1, 3, 0};
        logic [4:0] exp_stall;
        do_reset();
        for (int i = 0; i < 5; i++) set_ch(i, 1'b1, 6'(i + 1), 64'(32'h100 + i));
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_stall = 5'h1F & ~((5'd1 << first_ch[c]) | (5'd1 << second_ch[c]));
            n_vec++;
            if (unit_stall !== exp_stall) begin
                n_err++;
                $display("FAIL fair_stall_c%0d got %b want %b", c, unit_stall, exp_stall);
            end
            step();
            n_vec++;
            if (wb_en !== 2'b11 || wb_rn !== {6'(second_ch[c] + 1), 6'(first_ch[c] + 1)} ||
                wb_data !== {64'(32'h100 + second_ch[c]), 64'(32'h100 + first_ch[c])}) begin
                n_err++;
                $display("FAIL fair_wb_c%0d got en=%b rn=%h data=%h want ch %0d,%0d", c, wb_en, wb_rn, wb_data,
                         first_ch[c], second_ch[c]);
            end
            n_vec++;
            if (dut.rr_ptr_q !== 3'(ptr_after[c])) begin
                n_err++;
                $display("FAIL fair_ptr_c%0d got %0d want %0d", c, dut.rr_ptr_q, ptr_after[c]);
            end
        end
        clear_all();
    endtask

    task automatic test_dup_rn();
        do_reset();
        set_ch(1, 1'b1, 6'd9, 64'h11);
        set_ch(3, 1'b1, 6'd9, 64'h33);
        #1;
        n_vec++;
        if (unit_stall !== 5'b01000) begin
            n_err++;
            $display("FAIL dup_stall got %b want 01000", unit_stall);
        end
        step();
        n_vec++;
        if (wb_en !== 2'b01 || wb_rn[5:0] !== 6'd9 || wb_data[63:0] !== 64'h11 || dut.rr_ptr_q !== 3'd2) begin
            n_err++;
            $display("FAIL dup_n1 got en=%b rn=%0d data=%h ptr=%0d want 01 9 11 2", wb_en, wb_rn[5:0], wb_data[63:0],
                     dut.rr_ptr_q);
        end
        set_ch(1, 1'b0, 6'd0, 64'h0);
        step();
        n_vec++;
        if (wb_en !== 2'b01 || wb_rn[5:0] !== 6'd9 || wb_data[63:0] !== 64'h33 || dut.rr_ptr_q !== 3'd4) begin
            n_err++;
            $display("FAIL dup_n2 got en=%b rn=%0d data=%h ptr=%0d want 01 9 33 4", wb_en, wb_rn[5:0], wb_data[63:0],
                     dut.rr_ptr_q);
        end
        clear_all();
    endtask

    task automatic test_rn0_hold();
        set_ch(4, 1'b1, 6'd0, 64'hDEAD);
        #1;
        n_vec++;
        if (unit_stall !== 5'b00000) begin
            n_err++;
            $display("FAIL rn0_stall got %b want 00000", unit_stall);
        end
        step();
        n_vec++;
        if (wb_en !== 2'b00 || dut.rr_ptr_q !== 3'd4) begin
            n_err++;
            $display("FAIL rn0_wb got en=%b ptr=%0d want 00 4", wb_en, dut.rr_ptr_q);
        end
        set_ch(0, 1'b1, 6'd12, 64'h77);
        hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (unit_stall !== 5'b10001) begin
                n_err++;
                $display("FAIL hold_stall_c%0d got %b want 10001", c, unit_stall);
            end
            step();
            n_vec++;
            if (wb_en !== 2'b00 || dut.rr_ptr_q !== 3'd4) begin
                n_err++;
                $display("FAIL hold_wb_c%0d got en=%b ptr=%0d want 00 4", c, wb_en, dut.rr_ptr_q);
            end
        end
        hold = 1'b0;
        #1;
        n_vec++;
        if (unit_stall !== 5'b00000) begin
            n_err++;
            $display("FAIL release_stall got %b want 00000", unit_stall);
        end
        step();
        n_vec++;
        if (wb_en !== 2'b01 || wb_rn[5:0] !== 6'd12 || wb_data[63:0] !== 64'h77 || dut.rr_ptr_q !== 3'd1) begin
            n_err++;
            $display("FAIL release_wb got en=%b rn=%0d data=%h ptr=%0d want 01 12 77 1", wb_en, wb_rn[5:0],
                     wb_data[63:0], dut.rr_ptr_q);
        end
        clear_all();
    endtask

    task automatic test_bypass();
        do_reset();
        set_ch(2, 1'b1, 6'd3, 64'h55);
        #1;
`ifdef COMMIT_BYPASS_EN
        n_vec++;
        if (fwd_valid !== 2'b01 || fwd_rn[5:0] !== 6'd3 || fwd_data[63:0] !== 64'h55) begin
            n_err++;
            $display("FAIL bypass_fwd got v=%b rn=%0d data=%h want 01 3 55", fwd_valid, fwd_rn[5:0], fwd_data[63:0]);
        end
`else
        n_vec++;
        if (fwd_valid !== 2'b00 || fwd_rn !== 12'h0 || fwd_data !== 128'h0) begin
            n_err++;
            $display("FAIL bypass_off got v=%b rn=%h data=%h want 0", fwd_valid, fwd_rn, fwd_data);
        end
`endif
        step();
        n_vec++;
        if (wb_en !== 2'b01 || wb_rn[5:0] !== 6'd3 || wb_data[63:0] !== 64'h55) begin
            n_err++;
            $display("FAIL bypass_wb got en=%b rn=%0d data=%h want 01 3 55", wb_en, wb_rn[5:0], wb_data[63:0]);
        end
        clear_all();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ch(0, 1'b1, 6'd1, 64'h99);
        set_ch(1, 1'b1, 6'd2, 64'h98);
        step();
        n_vec++;
        if (wb_en !== 2'b11 || dut.rr_ptr_q !== 3'd2) begin
            n_err++;
            $display("FAIL mid_pre got en=%b ptr=%0d want 11 2", wb_en, dut.rr_ptr_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb_en !== 2'b00 || wb_data !== 128'h0 || dut.rr_ptr_q !== 3'd0) begin
            n_err++;
            $display("FAIL mid_rst got en=%b data=%h ptr=%0d want 0 0 0", wb_en, wb_data, dut.rr_ptr_q);
        end
        clear_all();
        #1;
        rst_n = 1'b1;
        step();
        n_vec++;
        if (wb_en !== 2'b00) begin
            n_err++;
            $display("FAIL mid_after got en=%b want 00", wb_en);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_all();
        test_reset();
        test_ports_default();
        test_fairness();
        test_dup_rn();
        test_rn0_hold();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

Parametrised writeback arbiter between the execution units and the register file. Collects results from NUM_UNITS execution channels and retires up to WB_PORTS of them per cycle onto registered register-file write ports. Uses fair round-robin selection and per-channel stall back-pressure. Writeback register numbers also feed the scheduler's finished-register inputs.

## Interface
Parameters:
- NUM_UNITS, 5, number of execution-unit channels (≥2)
- WB_PORTS, 2, register-file write ports (1..NUM_UNITS)
- DATA_W, 64, result width
- RN_W, 6, register-number width; rn 0 means "no destination"

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- unit_valid  in  NUM_UNITS  channel i presents a result
- unit_result  in  NUM_UNITS*DATA_W  result data, channel i at [i*DATA_W +: DATA_W]
- unit_rn  in  NUM_UNITS*RN_W  destination register, channel i at [i*RN_W +: RN_W]
- unit_stall  out  NUM_UNITS  channel i not accepted this cycle; hold valid/result/rn stable
- hold  in  1  register file unavailable; accept nothing
- wb_en  out  WB_PORTS  write port k active
- wb_rn  out  WB_PORTS*RN_W  write port k register number
- wb_data  out  WB_PORTS*DATA_W  write port k data
- fwd_valid  out  WB_PORTS  bypass: port k grant this cycle (see Configuration)
- fwd_rn  out  WB_PORTS*RN_W  bypass register number
- fwd_data  out  WB_PORTS*DATA_W  bypass data

## Operation
- Round-robin pointer rr_ptr, range 0..NUM_UNITS-1, reset 0.
- Each cycle with hold=0, scan channels rr_ptr, rr_ptr+1, … with wrap mod NUM_UNITS, once around.
- A channel with valid and rn==0 is always accepted. It consumes no port and causes no write.
- A channel with valid and rn≠0 is granted when both hold:
  - fewer than WB_PORTS ports are already taken;
  - no earlier-scanned channel this cycle was granted the same rn.
- Losers of a duplicate rn are deferred. Order is preserved by scan order.
- Granted channels take ports in scan order: the first grant gets port 0, and so on. Unused ports have wb_en=0.
- unit_stall[i] = unit_valid[i] & ~accepted[i], combinational, same cycle.
- A unit may drop valid only in a cycle where stall=0.
- Pointer update: if any channel with rn≠0 was granted, rr_ptr ← (index of last granted channel + 1) mod NUM_UNITS. Otherwise unchanged.
- hold=1:
  - no grants;
  - every valid channel stalled, including rn==0;
  - rr_ptr unchanged;
  - next-cycle wb_en all 0.
- The unit_result/unit_rn values of invalid channels are ignored.

## Timing
- Grant and stall are combinational from unit_valid, unit_rn, hold and rr_ptr.
- wb_* registered: the result accepted in cycle N appears on the write port in cycle N+1 for exactly one cycle.
- Throughput: up to WB_PORTS register writes per cycle, plus unlimited rn==0 retirements.
- Reset values: wb_en=0, wb_rn=0, wb_data=0, rr_ptr=0. fwd_* are 0 during reset.
- Reset mid-operation: pending results are lost, wb_en drops asynchronously, and the pointer returns to 0.
- Starvation bound: a continuously valid channel is granted within ceil(NUM_UNITS/WB_PORTS) cycles when its rn is not blocked by a duplicate and hold=0.

## Configuration
- COMMIT_BYPASS_EN defined: fwd_valid/fwd_rn/fwd_data carry the current-cycle grant mux outputs, combinationally, one cycle ahead of wb_*. This lets the operand read path forward.
- Undefined: fwd_* tied to 0. Ports remain present so the top level is unchanged.

## Structure
- Shared package commit_pkg holds:
  - DATA_W and RN_W defaults;
  - RN_NONE = 0;
  - helper function for the pointer width, clog2 of NUM_UNITS, minimum 1.
- One sub-module rr_select: given a request vector and a start pointer, it returns the first requester at or after the pointer, with wrap, as one-hot plus an index.
  - Used iteratively, one instance per write port.
  - Each instance masks prior grants and prior rns.
- Output registers and the pointer live in commit_arbiter.

## Test plan
- Reset: rst_n low with valids asserted → wb_en=0, stalls irrelevant. After release, rr_ptr=0 and the first grant comes from channel 0.
- Ports default: channels 0,1,2 valid, rn 5,6,7, data 0xA,0xB,0xC → cycle N+1: port0 (5,0xA), port1 (6,0xB); stall[2]=1 in N. Cycle N+2: port0 (7,0xC). rr_ptr=2 after N.
- Fairness: all 5 channels valid every cycle, distinct rn, WB_PORTS=2 → grant pairs (0,1), (2,3), (4,0), (1,2)…; no channel waits more than 3 cycles.
- Duplicate rn: channels 1 and 3 both rn=9, data 0x11/0x33, rr_ptr=0 → N+1: single write rn9=0x11, stall[3]=1. N+2: rn9=0x33.
- rn 0 and hold: channel 4 valid rn=0 with hold=0 → stall[4]=0, no wb_en. The same stimulus with hold=1 for 2 cycles → all stalled, wb_en=0, rr_ptr unchanged. Release → normal grant.
- Bypass: with COMMIT_BYPASS_EN, channel 2 rn=3 data 0x55 → fwd_valid[0]=1, fwd_rn=3, fwd_data=0x55 in cycle N and wb_* in N+1. Without the macro, fwd_* stay 0.
